// File: rtl/cam_pkg.sv
// Shared definitions for the camera frame writer: pixel-format codes, FSM states,
// reference RGB332 colours and the byte-pair to RGB332 conversion.
package cam_pkg;

  localparam logic [1:0] MODE_RGB565 = 2'd0;
  localparam logic [1:0] MODE_RGB444 = 2'd1;
  localparam logic [1:0] MODE_RAW    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    LINE  = 2'd2
  } state_t;

  localparam logic [7:0] RED   = 8'hE0;
  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] BLUE  = 8'h03;

  // The reserved mode code falls into the RGB565 branch.
  function automatic logic [7:0] to_rgb332(input logic [1:0] mode,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    case (mode)
      MODE_RGB444: return {hi[3:1], lo[7:5], lo[3:2]};
      MODE_RAW:    return lo;
      default:     return {hi[7:5], hi[2:0], lo[4:3]};
    endcase
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchroniser for one asynchronous camera signal, with a third flop
// so rising and falling edges can be detected in the system clock domain.
module cam_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/camera_frame_writer.sv
// Camera-bus to frame-buffer write path: synchronises the OV camera bus, builds
// RGB332 pixels, decimates, bounds-checks and emits registered write strobes.
module camera_frame_writer
  import cam_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int ADDR_W        = 15,
  parameter int DECIM_LOG2    = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PCLK,
  input  logic              HREF,
  input  logic              VSYNC,
  input  logic [7:0]        DATA,
  input  logic [1:0]        MODE,
  input  logic              CAPTURE_EN,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic [9:0]        X,
  output logic [9:0]        Y,
  output logic              FRAME_DONE,
  output logic [9:0]        LINE_COUNT,
  output logic              OVERRUN,
  output logic [1:0]        o_dbg_state
);

  localparam int DW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [9:0] W10 = 10'(SCREEN_WIDTH);
  localparam logic [9:0] H10 = 10'(SCREEN_HEIGHT);

  logic w_pclk_lvl, w_pclk_re, w_pclk_fall;
  logic w_href_lvl, w_href_rise, w_href_fall;
  logic w_vsync_lvl, w_vsync_rise, w_vsync_fall;
  logic w_unused_edges;

  cam_sync_edge u_sync_pclk (
    .i_clk(CLK), .i_rst(RESET), .i_async(PCLK),
    .o_level(w_pclk_lvl), .o_rise(w_pclk_re), .o_fall(w_pclk_fall)
  );
  cam_sync_edge u_sync_href (
    .i_clk(CLK), .i_rst(RESET), .i_async(HREF),
    .o_level(w_href_lvl), .o_rise(w_href_rise), .o_fall(w_href_fall)
  );
  cam_sync_edge u_sync_vsync (
    .i_clk(CLK), .i_rst(RESET), .i_async(VSYNC),
    .o_level(w_vsync_lvl), .o_rise(w_vsync_rise), .o_fall(w_vsync_fall)
  );

  assign w_unused_edges = &{1'b0, w_pclk_lvl, w_pclk_fall, w_href_rise, w_vsync_lvl};

  // DATA goes through the same depth as PCLK so the byte lines up with pclk_re.
  logic [7:0] r_data_s1;
  logic [7:0] r_data_s2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_data_s1 <= 8'h00;
      r_data_s2 <= 8'h00;
    end else begin
      r_data_s1 <= DATA;
      r_data_s2 <= r_data_s1;
    end
  end

  state_t r_state;
  state_t w_next;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_vsync_fall && CAPTURE_EN) w_next = FRAME;
      FRAME: begin
        if (w_vsync_rise)                 w_next = IDLE;
        else if (w_pclk_re && w_href_lvl) w_next = LINE;
      end
      LINE: begin
        if (w_vsync_rise)     w_next = IDLE;
        else if (w_href_fall) w_next = FRAME;
      end
      default: w_next = IDLE;
    endcase
  end

  logic w_start, w_byte, w_line_start, w_line_end, w_frame_end;

  always_comb begin
    w_start      = 1'b0;
    w_byte       = 1'b0;
    w_line_start = 1'b0;
    w_line_end   = 1'b0;
    w_frame_end  = 1'b0;
    case (r_state)
      IDLE: w_start = w_vsync_fall & CAPTURE_EN;
      FRAME: begin
        w_frame_end  = w_vsync_rise;
        w_byte       = w_pclk_re & w_href_lvl & ~w_vsync_rise;
        w_line_start = w_byte;
      end
      LINE: begin
        w_frame_end = w_vsync_rise;
        w_byte      = w_pclk_re & w_href_lvl & ~w_vsync_rise;
        w_line_end  = w_href_fall & ~w_vsync_rise;
      end
      default: ;
    endcase
  end

  logic              r_phase;
  logic [7:0]        r_hi;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [ADDR_W-1:0] r_row_base;
  logic [DW-1:0]     r_pdec;
  logic [DW-1:0]     r_ldec;
  logic [9:0]        r_line_cnt;

  logic          w_raw, w_pix, w_keep, w_in_bounds;
  logic [7:0]    w_pix_data;
  logic [DW-1:0] w_pdec_next, w_ldec_next;

  assign w_raw       = (MODE == MODE_RAW);
  assign w_pix       = w_byte & (w_raw | r_phase);
  assign w_pix_data  = to_rgb332(MODE, r_hi, r_data_s2);
  assign w_keep      = w_pix & (r_pdec == '0) & (r_ldec == '0);
  assign w_in_bounds = (r_x < W10) & (r_y < H10);
  assign w_pdec_next = (DECIM_LOG2 == 0) ? '0 : r_pdec + DW'(1);
  assign w_ldec_next = (DECIM_LOG2 == 0) ? '0 : r_ldec + DW'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      W_EN       <= 1'b0;
      W_ADDR     <= '0;
      W_DATA     <= 8'h00;
      FRAME_DONE <= 1'b0;
      LINE_COUNT <= 10'd0;
      OVERRUN    <= 1'b0;
      r_phase    <= 1'b0;
      r_hi       <= 8'h00;
      r_x        <= 10'd0;
      r_y        <= 10'd0;
      r_row_base <= '0;
      r_pdec     <= '0;
      r_ldec     <= '0;
      r_line_cnt <= 10'd0;
    end else begin
      W_EN       <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (w_start) begin
        r_x        <= 10'd0;
        r_y        <= 10'd0;
        r_row_base <= '0;
        r_pdec     <= '0;
        r_ldec     <= '0;
        r_phase    <= 1'b0;
        r_line_cnt <= 10'd0;
      end
      if (w_byte && !w_raw) begin
        r_phase <= ~r_phase;
        if (!r_phase) r_hi <= r_data_s2;
      end
      if (w_pix) r_pdec <= w_pdec_next;
      // Out-of-range pixels leave x parked at the limit and only flag OVERRUN.
      if (w_keep) begin
        if (w_in_bounds) begin
          W_EN   <= 1'b1;
          W_ADDR <= r_row_base + ADDR_W'(r_x);
          W_DATA <= w_pix_data;
          r_x    <= r_x + 10'd1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end
      if (w_line_start && r_line_cnt != 10'h3FF) r_line_cnt <= r_line_cnt + 10'd1;
      if (w_line_end) begin
        r_x     <= 10'd0;
        r_phase <= 1'b0;
        r_pdec  <= '0;
        r_ldec  <= w_ldec_next;
        if (r_ldec == '0 && r_y < H10) begin
          r_y        <= r_y + 10'd1;
          r_row_base <= r_row_base + ADDR_W'(SCREEN_WIDTH);
        end
      end
      if (w_frame_end) begin
        FRAME_DONE <= 1'b1;
        LINE_COUNT <= r_line_cnt;
        r_phase    <= 1'b0;
      end
    end
  end

  assign X           = r_x;
  assign Y           = r_y;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Directed bench for camera_frame_writer: one undecimated and one 2:1 decimated
// instance share the camera bus; writes are logged at negedge and compared.
module tb_camera_frame_writer;
  import cam_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pclk = 1'b0, href = 1'b0, vsync = 1'b1;
  logic [7:0]  data = 8'h00;
  logic [1:0]  mode = 2'd0;
  logic        cap_en = 1'b0;

  logic        w_en, frame_done, overrun;
  logic [14:0] w_addr;
  logic [7:0]  w_data;
  logic [9:0]  x, y, line_count;
  logic [1:0]  dbg_state;

  logic        d_w_en, d_frame_done, d_overrun;
  logic [14:0] d_w_addr;
  logic [7:0]  d_w_data;
  logic [9:0]  d_x, d_y, d_line_count;
  logic [1:0]  d_dbg_state;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0, dfd_cnt = 0, fd0 = 0, dfd0 = 0;
  logic [14:0] wa_q[$], dwa_q[$], exp_q[$];
  logic [7:0]  wd_q[$], dwd_q[$], exp_dq[$];

  always #5 clk = ~clk;

  camera_frame_writer #(.SCREEN_WIDTH(176), .SCREEN_HEIGHT(144), .ADDR_W(15), .DECIM_LOG2(0)) dut (
    .CLK(clk), .RESET(rst), .PCLK(pclk), .HREF(href), .VSYNC(vsync), .DATA(data),
    .MODE(mode), .CAPTURE_EN(cap_en), .W_EN(w_en), .W_ADDR(w_addr), .W_DATA(w_data),
    .X(x), .Y(y), .FRAME_DONE(frame_done), .LINE_COUNT(line_count), .OVERRUN(overrun),
    .o_dbg_state(dbg_state)
  );

  camera_frame_writer #(.SCREEN_WIDTH(176), .SCREEN_HEIGHT(144), .ADDR_W(15), .DECIM_LOG2(1)) dut_d (
    .CLK(clk), .RESET(rst), .PCLK(pclk), .HREF(href), .VSYNC(vsync), .DATA(data),
    .MODE(mode), .CAPTURE_EN(cap_en), .W_EN(d_w_en), .W_ADDR(d_w_addr), .W_DATA(d_w_data),
    .X(d_x), .Y(d_y), .FRAME_DONE(d_frame_done), .LINE_COUNT(d_line_count), .OVERRUN(d_overrun),
    .o_dbg_state(d_dbg_state)
  );

  always @(negedge clk) begin
    if (w_en) begin wa_q.push_back(w_addr); wd_q.push_back(w_data); end
    if (d_w_en) begin dwa_q.push_back(d_w_addr); dwd_q.push_back(d_w_data); end
    if (frame_done) fd_cnt++;
    if (d_frame_done) dfd_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); dwa_q.delete(); dwd_q.delete();
    exp_q.delete(); exp_dq.delete();
    fd0 = fd_cnt; dfd0 = dfd_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    wait_clk(4);
    pclk = 1'b1;
    wait_clk(4);
    pclk = 1'b0;
  endtask

  task automatic href_begin();
    href = 1'b1;
    wait_clk(4);
  endtask

  task automatic href_end();
    wait_clk(4);
    href = 1'b0;
    wait_clk(8);
  endtask

  task automatic send_line(input logic [7:0] b0, input logic [7:0] b1, input int n);
    href_begin();
    for (int i = 0; i < n; i++) send_byte((i % 2) ? b1 : b0);
    href_end();
  endtask

  task automatic frame_start();
    vsync = 1'b1;
    wait_clk(8);
    vsync = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_end();
    vsync = 1'b1;
    wait_clk(12);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    total++;
    if ({w_en, w_addr, w_data, x, y, frame_done, line_count, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got en=%0b addr=%0d data=%h x=%0d y=%0d fd=%0b lc=%0d ov=%0b, want all 0",
               w_en, w_addr, w_data, x, y, frame_done, line_count, overrun);
    end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_rgb565();
    logic [14:0] e;
    logic [14:0] a;
    logic [7:0]  d;
    mode = MODE_RGB565; cap_en = 1'b1;
    clear_mon();
    frame_start();
    send_line(8'hF8, 8'h00, 8);
    send_line(8'hF8, 8'h00, 8);
    frame_end();
    exp_q = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd176, 15'd177, 15'd178, 15'd179};
    total++;
    if (wa_q.size() != 8) begin bad++; $display("FAIL rgb565_count: got %0d writes want 8", wa_q.size()); end
    while (exp_q.size() > 0 && wa_q.size() > 0) begin
      e = exp_q.pop_front(); a = wa_q.pop_front(); d = wd_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL rgb565_addr: got %0d want %0d", a, e); end
      total++;
      if (d !== RED) begin bad++; $display("FAIL rgb565_data: got %h want %h", d, RED); end
    end
    total++;
    if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL rgb565_frame_done: got %0d pulses want 1", fd_cnt - fd0); end
    total++;
    if (line_count !== 10'd2) begin bad++; $display("FAIL rgb565_line_count: got %0d want 2", line_count); end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL rgb565_idle: got state %0d want 0", dbg_state); end
  endtask

  task automatic test_rgb444();
    logic [14:0] e;
    logic [7:0]  ed;
    logic [14:0] a;
    logic [7:0]  d;
    mode = MODE_RGB444; cap_en = 1'b1;
    clear_mon();
    frame_start();
    href_begin();
    send_byte(8'h0F); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'hF0);
    send_byte(8'h00); send_byte(8'h0F);
    href_end();
    frame_end();
    exp_q  = '{15'd0, 15'd1, 15'd2};
    exp_dq = '{RED, GREEN, BLUE};
    total++;
    if (wa_q.size() != 3) begin bad++; $display("FAIL rgb444_count: got %0d writes want 3", wa_q.size()); end
    while (exp_q.size() > 0 && wa_q.size() > 0) begin
      e = exp_q.pop_front(); ed = exp_dq.pop_front();
      a = wa_q.pop_front(); d = wd_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL rgb444_addr: got %0d want %0d", a, e); end
      total++;
      if (d !== ed) begin bad++; $display("FAIL rgb444_data: got %h want %h", d, ed); end
    end
  endtask

  task automatic test_decim();
    logic [14:0] e;
    logic [7:0]  ed;
    logic [14:0] a;
    logic [7:0]  d;
    mode = MODE_RAW; cap_en = 1'b1;
    clear_mon();
    frame_start();
    for (int l = 0; l < 4; l++) begin
      href_begin();
      for (int i = 0; i < 8; i++) send_byte(8'(l * 8 + i));
      href_end();
    end
    frame_end();
    exp_q  = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd176, 15'd177, 15'd178, 15'd179};
    exp_dq = '{8'd0, 8'd2, 8'd4, 8'd6, 8'd16, 8'd18, 8'd20, 8'd22};
    total++;
    if (dwa_q.size() != 8) begin bad++; $display("FAIL decim_count: got %0d writes want 8", dwa_q.size()); end
    while (exp_q.size() > 0 && dwa_q.size() > 0) begin
      e = exp_q.pop_front(); ed = exp_dq.pop_front();
      a = dwa_q.pop_front(); d = dwd_q.pop_front();
      total++;
      if (a !== e) begin bad++; $display("FAIL decim_addr: got %0d want %0d", a, e); end
      total++;
      if (d !== ed) begin bad++; $display("FAIL decim_data: got %0d want %0d", d, ed); end
    end
    total++;
    if (d_line_count !== 10'd4) begin bad++; $display("FAIL decim_line_count: got %0d want 4", d_line_count); end
    total++;
    if (dfd_cnt - dfd0 != 1) begin bad++; $display("FAIL decim_frame_done: got %0d want 1", dfd_cnt - dfd0); end
    total++;
    if (wa_q.size() != 32) begin bad++; $display("FAIL raw_count: got %0d writes want 32", wa_q.size()); end
    else begin
      total++;
      if (wa_q[31] !== 15'd535 || wd_q[31] !== 8'd31) begin
        bad++; $display("FAIL raw_last: got addr %0d data %0d want 535 31", wa_q[31], wd_q[31]);
      end
    end
  endtask

  task automatic test_capture_disable();
    mode = MODE_RGB565; cap_en = 1'b0;
    clear_mon();
    frame_start();
    send_line(8'hF8, 8'h00, 8);
    frame_end();
    total++;
    if (wa_q.size() != 0 || fd_cnt - fd0 != 0) begin
      bad++; $display("FAIL capture_disabled: got %0d writes %0d pulses want 0 0", wa_q.size(), fd_cnt - fd0);
    end
    cap_en = 1'b1;
  endtask

  task automatic test_overrun();
    int viol;
    mode = MODE_RGB565; cap_en = 1'b1;
    clear_mon();
    frame_start();
    href_begin();
    for (int i = 0; i < 176; i++) begin send_byte(8'hF8); send_byte(8'h00); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_early: got %0b want 0 after 176 pixels", overrun); end
    total++;
    if (x !== 10'd176) begin bad++; $display("FAIL overrun_x: got %0d want 176", x); end
    send_byte(8'hF8); send_byte(8'h00);
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %0b want 1 after 177th pixel", overrun); end
    for (int i = 0; i < 3; i++) begin send_byte(8'hF8); send_byte(8'h00); end
    total++;
    if (x !== 10'd176) begin bad++; $display("FAIL overrun_x_sat: got %0d want 176", x); end
    href_end();
    frame_end();
    total++;
    if (wa_q.size() != 176) begin bad++; $display("FAIL overrun_count: got %0d writes want 176", wa_q.size()); end
    viol = 0;
    foreach (wa_q[i]) if (wa_q[i] >= 15'd176 || wa_q[i] !== 15'(i)) viol++;
    total++;
    if (viol != 0) begin bad++; $display("FAIL overrun_addr: got %0d bad addresses want 0", viol); end
  endtask

  task automatic test_reset_mid();
    mode = MODE_RGB565; cap_en = 1'b1;
    clear_mon();
    frame_start();
    send_line(8'hF8, 8'h00, 8);
    href_begin();
    for (int i = 0; i < 4; i++) send_byte((i % 2) ? 8'h00 : 8'hF8);
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    total++;
    if (dbg_state !== 2'd0 || overrun !== 1'b0) begin
      bad++; $display("FAIL reset_mid_state: got state %0d overrun %0b want 0 0", dbg_state, overrun);
    end
    clear_mon();
    for (int i = 0; i < 4; i++) send_byte((i % 2) ? 8'h00 : 8'hF8);
    href_end();
    send_line(8'hF8, 8'h00, 8);
    frame_end();
    total++;
    if (wa_q.size() != 0 || fd_cnt - fd0 != 0) begin
      bad++; $display("FAIL reset_mid_partial: got %0d writes %0d pulses want 0 0", wa_q.size(), fd_cnt - fd0);
    end
    clear_mon();
    frame_start();
    send_line(8'hF8, 8'h00, 8);
    send_line(8'hF8, 8'h00, 8);
    frame_end();
    total++;
    if (wa_q.size() != 8) begin bad++; $display("FAIL reset_mid_count: got %0d writes want 8", wa_q.size()); end
    else begin
      total++;
      if (wa_q[0] !== 15'd0 || wa_q[7] !== 15'd179) begin
        bad++; $display("FAIL reset_mid_addr: got first %0d last %0d want 0 179", wa_q[0], wa_q[7]);
      end
    end
    total++;
    if (fd_cnt - fd0 != 1 || line_count !== 10'd2) begin
      bad++; $display("FAIL reset_mid_frame: got %0d pulses lc %0d want 1 2", fd_cnt - fd0, line_count);
    end
  endtask

  task automatic test_abort();
    mode = MODE_RGB565; cap_en = 1'b1;
    clear_mon();
    frame_start();
    href_begin();
    send_byte(8'hF8); send_byte(8'h00); send_byte(8'hF8);
    wait_clk(4);
    vsync = 1'b1;
    wait_clk(8);
    total++;
    if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL abort_frame_done: got %0d want 1", fd_cnt - fd0); end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL abort_idle: got state %0d want 0", dbg_state); end
    href = 1'b0;
    wait_clk(8);
    total++;
    if (wa_q.size() != 1) begin bad++; $display("FAIL abort_count: got %0d writes want 1", wa_q.size()); end
    else begin
      total++;
      if (wa_q[0] !== 15'd0 || wd_q[0] !== RED) begin
        bad++; $display("FAIL abort_write: got addr %0d data %h want 0 %h", wa_q[0], wd_q[0], RED);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rgb565();
    test_rgb444();
    test_decim();
    test_capture_disable();
    test_overrun();
    test_reset_mid();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camera_frame_writer.md
Name: camera_frame_writer

Overview:
Parametrised successor to the top-level camera-to-M9K write path. Samples the OV-series camera bus (PCLK, HREF, VSYNC, 8-bit data) in the system clock domain, assembles two-byte pixels, converts them to RGB332 and produces write address, data and enable for the dual-port frame buffer. Frame size, pixel format and decimation are configurable. The block also reports frame boundaries, so the image processor and the VGA side can align to complete frames.

Parameters:
SCREEN_WIDTH, 176, stored pixels per line
SCREEN_HEIGHT, 144, stored lines per frame
ADDR_W, 15, width of write address; must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT
DECIM_LOG2, 0, keep every 2^DECIM_LOG2-th pixel and line (0 means no decimation)

Ports:
CLK  in  1  system clock; required to be at least 4x PCLK
RESET  in  1  synchronous, active-high reset
PCLK  in  1  camera pixel clock, asynchronous
HREF  in  1  camera line-valid, asynchronous
VSYNC  in  1  camera frame sync (high means blanking), asynchronous
DATA  in  8  camera byte bus
MODE  in  2  pixel format: 0 RGB565, 1 RGB444 (xRGB), 2 raw byte (one byte per pixel), 3 reserved (treated as 0)
CAPTURE_EN  in  1  arm capture; sampled only at frame start
W_EN  out  1  one-cycle frame-buffer write strobe
W_ADDR  out  ADDR_W  write address
W_DATA  out  8  RGB332 pixel
X  out  10  current stored-pixel column
Y  out  10  current stored-pixel row
FRAME_DONE  out  1  one-cycle pulse at the end of each captured frame
LINE_COUNT  out  10  HREF lines seen in the last completed frame
OVERRUN  out  1  sticky: a frame had more than SCREEN_WIDTH pixels per line or more than SCREEN_HEIGHT lines

Behaviour:
- Synchronisation: PCLK, HREF, VSYNC and DATA each pass through 2 flops. A PCLK rising edge (pclk_re) is detected as s2 & ~s3. HREF and VSYNC edges are taken from the s2/s3 pair. All actions below occur in the cycle after pclk_re or after the edge is detected.
- Reset values: every output is 0; the state is IDLE; the byte phase is 0.
- States:
  - IDLE: on VSYNC falling with CAPTURE_EN=1, go to FRAME; x, y, row_base and the decimation counters clear to 0.
  - FRAME: HREF high, sampled on pclk_re, moves to LINE. VSYNC rising: pulse FRAME_DONE, latch LINE_COUNT, go to IDLE.
  - LINE:
    - On pclk_re with HREF=1, capture a byte.
    - In MODE 0/1, phase 0 stores byte hi; phase 1 forms the pixel. In MODE 2, every byte is a pixel.
    - On HREF falling: y-step, x=0, phase=0, go to FRAME. An odd trailing byte is discarded.
    - VSYNC rising while in LINE aborts the line, then behaves as in FRAME.
- Conversion: in RGB565, {hi[7:5], hi[2:0], lo[4:3]}. In RGB444, {hi[3:1], lo[7:5], lo[3:2]}. In raw mode, the byte is passed through unchanged.
- Decimation:
  - A pixel is stored only when the pixel decimation counter is 0. The counter wraps at 2^DECIM_LOG2.
  - Lines are handled the same way with the line counter, which advances on each HREF falling edge.
  - x increments only on stored pixels. y and row_base advance only after a stored line.
- Address: W_ADDR = row_base + x. row_base is incremented by SCREEN_WIDTH per stored line, with no multiplier. W_EN, W_ADDR and W_DATA are registered together, with W_EN high for exactly 1 CLK.
- Bounds: a pixel with x >= SCREEN_WIDTH or y >= SCREEN_HEIGHT is not written (W_EN stays 0), x saturates, and OVERRUN is set. OVERRUN is cleared only by RESET.
- LINE_COUNT counts every HREF line of the frame, before decimation, and saturates at 1023.
- RESET mid-frame returns the block to IDLE. Capture then waits for the next VSYNC falling edge; no partial frame is written.
- CAPTURE_EN deasserted mid-frame has no effect until the next frame start.

Decomposition:
- Shared package cam_pkg: MODE encodings (MODE_RGB565=0, MODE_RGB444=1, MODE_RAW=2), state enum {IDLE, FRAME, LINE}, and the RGB332 colour constants RED/GREEN/BLUE.
- Sub-module cam_sync_edge: 2-flop synchroniser plus edge detector, instantiated for PCLK, HREF and VSYNC.

Test Plan:
- MODE 0, 2-line by 4-pixel frame, bytes 0xF8,0x00 repeated → 8 writes, data 0xE0, addresses 0..3 and 176..179. FRAME_DONE pulses once; LINE_COUNT=2.
- MODE 1, bytes 0x0F,0x00 → W_DATA=0xE0. Bytes 0x00,0xF0 → 0x1C. Bytes 0x00,0x0F → 0x03.
- MODE 2, DECIM_LOG2=1, 4 lines of 8 bytes → 8 writes, addresses 0..3 and 176..179. LINE_COUNT=4.
- 180 pixels per line in MODE 0 → writes for x=0..175 only; OVERRUN=1 after the 177th pixel, with no address ≥ 176 on row 0.
- RESET asserted in the middle of line 1, released, then a full frame sent → writes start again at address 0 only after the next VSYNC falling edge.
- VSYNC rising during HREF high with an odd byte pending → no write for the pending byte; FRAME_DONE pulses; state returns to IDLE.
